// File: rtl/dmem_handshake_responder_if.sv
// Bus between the MEM stage (master) and the multi-cycle data-memory responder (slave).
interface dmem_handshake_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [31:0] ReadData;
    logic        stall;
    logic        ack;
    logic        misaligned;

    modport master (
        output MemRead, MemWrite, address, writedata,
        input  ReadData, stall, ack, misaligned
    );

    modport slave (
        input  MemRead, MemWrite, address, writedata,
        output ReadData, stall, ack, misaligned
    );
endinterface

// File: rtl/dmem_handshake_responder.sv
// Multi-cycle data-memory responder: level-held load/store, stall while outstanding, ack pulse on completion.
// Optional alignment checking is compiled in by defining DMEM_ALIGN_CHECK_EN.
module dmem_handshake_responder #(
    parameter int DEPTH   = 512,
    parameter int LATENCY = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    dmem_handshake_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_next;
    logic          r_wr;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rdata;

    logic          w_req;
    logic          w_accept;
    logic          w_commit;
    logic [AW-1:0] w_cm_idx;
    logic [31:0]   w_cm_wdata;
    logic          w_cm_wr;
    logic          w_cm_mis;
    logic          w_we;
    logic          w_unused_addr;

    assign w_req         = bus.MemRead | bus.MemWrite;
    assign w_unused_addr = ^{bus.address[31:AW+2], bus.address[1:0]};

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_next = ACK;
                        w_commit     = 1'b1;
                    end else begin
                        w_state_next = BUSY;
                        w_cnt_next   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = ACK;
                    w_commit     = 1'b1;
                end
            end
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) r_wr <= bus.MemWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idx   <= bus.address[AW+1:2];
            r_wdata <= bus.writedata;
        end
    end

    // With LATENCY=1 the commit shares the accept edge, so the live request is used.
    always_comb begin
        if (r_state == IDLE) begin
            w_cm_idx   = bus.address[AW+1:2];
            w_cm_wdata = bus.writedata;
            w_cm_wr    = bus.MemWrite;
        end else begin
            w_cm_idx   = r_idx;
            w_cm_wdata = r_wdata;
            w_cm_wr    = r_wr;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] r_lo;
    logic       r_mis;

    always_ff @(posedge clk) begin
        if (w_accept) r_lo <= bus.address[1:0];
    end

    assign w_cm_mis = (r_state == IDLE) ? (bus.address[1:0] != 2'b00) : (r_lo != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_mis <= 1'b0;
        else if (w_commit) r_mis <= w_cm_mis;
    end

    assign bus.misaligned = r_mis;
`else
    assign w_cm_mis       = 1'b0;
    assign bus.misaligned = 1'b0;
`endif

    assign w_we = w_commit & w_cm_wr & ~w_cm_mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rdata <= '0;
        end else if (w_commit) begin
            if (w_we) r_mem[w_cm_idx] <= w_cm_wdata;
            r_rdata <= w_cm_mis ? 32'h0 : (w_cm_wr ? w_cm_wdata : r_mem[w_cm_idx]);
        end
    end

    assign bus.ReadData = r_rdata;
    assign bus.stall    = ((r_state == IDLE) && w_req) || (r_state == BUSY);
    assign bus.ack      = (r_state == ACK);
endmodule
